jpeg_bit_buffer: RTL

JPEG_BIT_BUFFER -- requirements
Module: jpeg_bit_buffer

---
 rtl/jpeg_bit_buffer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/jpeg_bit_buffer.sv
// jpeg_bit_buffer
//   Bit buffer between the JPEG entropy-coded byte stream and the Huffman
//   (DHT) lookup. Bytes are appended MSB-first into a 64-bit left-aligned
//   shift register. The decoder looks at the top 16 bits and removes up to
//   16 bits per cycle from the head.
//
//   Optional feature macro: JPEG_BITBUF_UNSTUFF_EN
//     defined   : byte-unstuffing FSM. A 0xFF,0x00 pair keeps only the 0xFF.
//                 0xFF followed by a non-zero byte sets the sticky marker_o.
//     undefined : every accepted byte is appended unmodified and
//                 marker_o is tied to 0.
//
// Ports
//   clk_i            : clock for all state
//   rst_i            : synchronous active-high reset (overrides everything)
//   inport_valid_i   : byte offered
//   inport_data_i    : offered byte
//   inport_last_i    : offered byte is the final byte of the scan
//   inport_accept_o  : offered byte is taken this cycle
//   flush_i          : discard all buffered bits on the next cycle
//   outport_data_o   : top 16 bits of the buffer (MSB-first lookup window)
//   outport_valid_o  : window holds >= 16 bits, or the stream ended with bits left
//   outport_level_o  : number of valid buffered bits (0..64)
//   consume_i        : remove bits from the window head
//   consume_width_i  : number of bits to remove (values above 16 act as 16)
//   marker_o         : sticky marker-detected flag
//   eof_o            : last byte has been accepted
module jpeg_bit_buffer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_valid_i,
  input  logic [7:0]  inport_data_i,
  input  logic        inport_last_i,
  output logic        inport_accept_o,
  input  logic        flush_i,
  output logic [15:0] outport_data_o,
  output logic        outport_valid_o,
  output logic [6:0]  outport_level_o,
  input  logic        consume_i,
  input  logic [4:0]  consume_width_i,
  output logic        marker_o,
  output logic        eof_o
);

  logic [63:0] buffer_r;
  logic [6:0]  level_r;
  logic        eof_r;
  logic        marker_r;
  logic        valid_r;

  logic        accept_s;
  logic        take_s;
  logic        drop_s;
  logic        marker_set_s;
  logic [4:0]  width_s;
  logic [63:0] shifted_s;
  logic [6:0]  level_post_s;
  logic [63:0] buffer_next_s;
  logic [6:0]  level_next_s;
  logic        eof_next_s;
  logic        marker_next_s;
  logic        valid_next_s;

`ifdef JPEG_BITBUF_UNSTUFF_EN
  typedef enum logic {
    NORMAL  = 1'b0,
    SEEN_FF = 1'b1
  } unstuff_state_t;

  unstuff_state_t state_r;
  unstuff_state_t state_next_s;

  // Unstuff FSM state register; flush and reset make the next byte stream-initial.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= NORMAL;
    end else if (flush_i) begin
      state_r <= NORMAL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Unstuff FSM next state: decide whether the taken byte is dropped or flags a marker.
  always_comb begin
    state_next_s = state_r;
    drop_s       = 1'b0;
    marker_set_s = 1'b0;
    if (take_s) begin
      case (state_r)
        NORMAL: begin
          if (inport_data_i == 8'hFF) begin
            state_next_s = SEEN_FF;
          end else begin
            state_next_s = NORMAL;
          end
        end
        SEEN_FF: begin
          if (inport_data_i == 8'h00) begin
            // Stuffed zero: consumed from the stream but never appended.
            drop_s       = 1'b1;
            state_next_s = NORMAL;
          end else if (inport_data_i == 8'hFF) begin
            // 0xFF fill bytes: keep waiting for the byte that follows.
            state_next_s = SEEN_FF;
          end else begin
            marker_set_s = 1'b1;
            state_next_s = NORMAL;
          end
        end
        default: begin
          state_next_s = NORMAL;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end
`else
  assign drop_s       = 1'b0;
  assign marker_set_s = 1'b0;
`endif

  // Accept rule: room for a whole byte, stream not ended, no flush or reset pending.
  always_comb begin
    accept_s = 1'b0;
    if (rst_i || flush_i || eof_r) begin
      accept_s = 1'b0;
    end else if (level_r <= 7'd56) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    take_s = inport_valid_i && accept_s;
  end

  // Datapath next state: the consume is applied first, then the byte lands at the post-consume level.
  always_comb begin
    width_s       = 5'd0;
    shifted_s     = buffer_r;
    level_post_s  = level_r;
    buffer_next_s = buffer_r;
    level_next_s  = level_r;

    if (consume_width_i > 5'd16) begin
      width_s = 5'd16;
    end else begin
      width_s = consume_width_i;
    end

    if (consume_i) begin
      // Bits below the level are always zero, so shifting past the level is harmless.
      shifted_s = buffer_r << width_s;
      if (level_r >= {2'b00, width_s}) begin
        level_post_s = level_r - {2'b00, width_s};
      end else begin
        level_post_s = 7'd0;
      end
    end else begin
      shifted_s    = buffer_r;
      level_post_s = level_r;
    end

    // level_post_s <= 56 whenever take_s is set, so the byte always fits.
    if (take_s && !drop_s) begin
      buffer_next_s = shifted_s | ({inport_data_i, 56'd0} >> level_post_s);
      level_next_s  = level_post_s + 7'd8;
    end else begin
      buffer_next_s = shifted_s;
      level_next_s  = level_post_s;
    end

    eof_next_s    = eof_r | (take_s & inport_last_i);
    marker_next_s = marker_r | marker_set_s;
    valid_next_s  = (level_next_s >= 7'd16) || (eof_next_s && (level_next_s != 7'd0));
  end

  // Buffer, level and status registers; reset beats flush, flush beats consume/accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buffer_r <= 64'd0;
      level_r  <= 7'd0;
      eof_r    <= 1'b0;
      marker_r <= 1'b0;
      valid_r  <= 1'b0;
    end else if (flush_i) begin
      buffer_r <= 64'd0;
      level_r  <= 7'd0;
      eof_r    <= 1'b0;
      marker_r <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      buffer_r <= buffer_next_s;
      level_r  <= level_next_s;
      eof_r    <= eof_next_s;
      marker_r <= marker_next_s;
      valid_r  <= valid_next_s;
    end
  end

  assign inport_accept_o = accept_s;
  assign outport_data_o  = buffer_r[63:48];
  assign outport_valid_o = valid_r;
  assign outport_level_o = level_r;
  assign eof_o           = eof_r;
  assign marker_o        = marker_r;

endmodule
